vec_opnd_fetch: RTL and testbench

Read-side sequencer for the vector register file (VRF). Accepts one vector micro-instruction at a time with up to three source register specifiers and an LMUL register-group size. Drives the VRF read ports: rd_en, rd_addr and rd_data (registered, one-cycle latency, holds while rd_en is low). Streams one operand beat per register of the group to the execute stage over a valid/ready handshake.

---
 rtl/vec_opnd_fetch_if.sv | 30 +++
 rtl/vec_opnd_fetch.sv | 91 +++++++++
 tb/tb_vec_opnd_fetch.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/vec_opnd_fetch_if.sv
// vec_opnd_fetch_if: request, VRF read-port and operand-beat bundle; master = sequencer, slave = environment
interface vec_opnd_fetch_if #(
   parameter int XLEN  = 512,
   parameter int TAG_W = 4
);
   logic                       req_valid;
   logic                       req_ready;
   logic [2:0][4:0]            req_vs;
   logic [2:0]                 req_src_en;
   logic [1:0]                 req_lmul_log2;
   logic [TAG_W-1:0]           req_tag;
   logic [2:0]                 rd_en;
   logic [2:0][4:0]            rd_addr;
   logic [2:0][XLEN-1:0]       rd_data;
   logic                       out_valid;
   logic                       out_ready;
   logic [2:0][XLEN-1:0]       out_opnd;
   logic [2:0]                 out_idx;
   logic                       out_last;
   logic [TAG_W-1:0]           out_tag;
   logic                       out_err;
   modport master (
      input  req_valid, req_vs, req_src_en, req_lmul_log2, req_tag, rd_data, out_ready,
      output req_ready, rd_en, rd_addr, out_valid, out_opnd, out_idx, out_last, out_tag, out_err
   );
   modport slave (
      output req_valid, req_vs, req_src_en, req_lmul_log2, req_tag, rd_data, out_ready,
      input  req_ready, rd_en, rd_addr, out_valid, out_opnd, out_idx, out_last, out_tag, out_err
   );
endinterface

// File: rtl/vec_opnd_fetch.sv
// vec_opnd_fetch: VRF read sequencer streaming one operand beat per group register; VEC_OPF_ALIGN_CHK_EN enables the misaligned-group error beat
module vec_opnd_fetch #(
   parameter int XLEN  = 512,
   parameter int TAG_W = 4
) (
   input logic clk,
   input logic rst_n,
   vec_opnd_fetch_if.master bus
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   logic [1:0]       state;
   logic [2:0][4:0]  vs_q;
   logic [2:0]       en_q, nm1_q, cnt, req_nm1, idx_q;
   logic             issue, acc, mis, err, valid_q, last_q;
   logic [TAG_W-1:0] tag_q;
   assign req_nm1       = ~(3'b111 << bus.req_lmul_log2);
   assign bus.req_ready = state == IDLE;
   assign acc           = bus.req_ready && bus.req_valid;
   assign issue         = state == ISSUE && (!valid_q || bus.out_ready);
   assign bus.out_valid = valid_q;
   assign bus.out_idx   = idx_q;
   assign bus.out_last  = last_q;
   assign bus.out_tag   = tag_q;
   assign bus.out_err   = err;
`ifdef VEC_OPF_ALIGN_CHK_EN
   logic err_q;
   assign mis = |(bus.req_src_en & {|(bus.req_vs[2][2:0] & req_nm1),
                                    |(bus.req_vs[1][2:0] & req_nm1),
                                    |(bus.req_vs[0][2:0] & req_nm1)});
   assign err = err_q;
   // error flag belongs to the accepted instruction and lives until the next accept
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) err_q <= 1'b0;
      else if (acc) err_q <= mis;
`else
   assign mis = 1'b0;
   assign err = 1'b0;
`endif
   for (genvar i = 0; i < 3; i++) begin : g_port
      assign bus.rd_en[i]    = issue & en_q[i];
      assign bus.rd_addr[i]  = vs_q[i] + {2'b00, cnt};
      assign bus.out_opnd[i] = en_q[i] && !err ? bus.rd_data[i] : '0;
   end
   // sequencer: latch the instruction, step through the group, wait for the last beat
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         vs_q  <= '0;
         en_q  <= '0;
         nm1_q <= '0;
         cnt   <= '0;
         tag_q <= '0;
      end else
         case (state)
            IDLE:
               if (bus.req_valid) begin
                  vs_q  <= bus.req_vs;
                  en_q  <= bus.req_src_en;
                  nm1_q <= req_nm1;
                  tag_q <= bus.req_tag;
                  cnt   <= '0;
                  state <= mis ? DRAIN : ISSUE;
               end
            ISSUE:
               if (issue) begin
                  cnt <= cnt + 3'd1;
                  if (cnt == nm1_q) state <= DRAIN;
               end
            DRAIN:
               if (valid_q && bus.out_ready && last_q) state <= IDLE;
            default: state <= IDLE;
         endcase
   // beat register: a read this cycle becomes the visible beat next cycle, else it clears on handshake
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         valid_q <= 1'b0;
         idx_q   <= '0;
         last_q  <= 1'b0;
      end else if (acc && mis) begin
         valid_q <= 1'b1;
         idx_q   <= '0;
         last_q  <= 1'b1;
      end else if (issue) begin
         valid_q <= 1'b1;
         idx_q   <= cnt;
         last_q  <= cnt == nm1_q;
      end else if (valid_q && bus.out_ready)
         valid_q <= 1'b0;
endmodule

// File: tb/tb_vec_opnd_fetch.sv
// tb_vec_opnd_fetch: directed and random instructions checked against a per-instruction beat/read model
module tb_vec_opnd_fetch;
   localparam int XLEN  = 512;
   localparam int TAG_W = 4;
   typedef struct {
      logic [2:0]           idx;
      logic                 last;
      logic [TAG_W-1:0]     tag;
      logic                 err;
      logic [2:0][XLEN-1:0] op;
   } beat_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [XLEN-1:0] vrf [32];
   beat_t bq[$];
   logic [4:0] rq[3][$];
   int checks = 0;
   int passes = 0;
   int stall_left = 0;
   always #5 clk = ~clk;
   vec_opnd_fetch_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();
   vec_opnd_fetch #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   // VRF read ports: one-cycle latency, data holds while rd_en is low
   always @(posedge clk)
      for (int i = 0; i < 3; i++)
         if (bus.rd_en[i]) bus.rd_data[i] <= vrf[bus.rd_addr[i]];
   task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
      checks++;
      assert (got === exp) passes++;
      else $error("FAIL %s got %0h expected %0h", tag, got, exp);
   endtask
   task automatic monitor();
      beat_t b;
      if (bus.out_valid && !bus.out_ready) begin
         chk("stall_rd_en", bus.rd_en, 0);
         if (bq.size() != 0) chk("stall_opnd0", bus.out_opnd[0], bq[0].op[0]);
      end
      if (bus.out_valid && bus.out_ready) begin
         if (bq.size() == 0) chk("beat_extra", bus.out_valid, 0);
         else begin
            b = bq.pop_front();
            chk("beat_idx", bus.out_idx, b.idx);
            chk("beat_last", bus.out_last, b.last);
            chk("beat_tag", bus.out_tag, b.tag);
            chk("beat_err", bus.out_err, b.err);
            for (int i = 0; i < 3; i++) chk("beat_opnd", bus.out_opnd[i], b.op[i]);
         end
      end
      for (int i = 0; i < 3; i++)
         if (rq[i].size() == 0) chk("rd_idle", bus.rd_en[i], 0);
         else if (bus.rd_en[i]) chk("rd_addr", bus.rd_addr[i], rq[i].pop_front());
   endtask
   task automatic tick(input int mode);
      @(negedge clk);
      if (mode == 1) bus.out_ready = $urandom_range(0, 3) != 0;
      else if (mode == 2 && bus.out_valid && bus.out_idx == 3'd2 && stall_left > 0) begin
         bus.out_ready = 1'b0;
         stall_left--;
      end else bus.out_ready = 1'b1;
      #1;
      monitor();
   endtask
   task automatic push_exp(input logic [2:0][4:0] vs, input logic [2:0] en, input logic [1:0] lmul,
                           input logic [TAG_W-1:0] tag, output bit mis);
      int n;
      beat_t b;
      n = 1 << lmul;
      mis = 1'b0;
`ifdef VEC_OPF_ALIGN_CHK_EN
      for (int i = 0; i < 3; i++) if (en[i] && (int'(vs[i]) % n) != 0) mis = 1'b1;
`endif
      b.tag = tag;
      if (mis) begin
         b.idx = 3'd0; b.last = 1'b1; b.err = 1'b1; b.op = '0;
         bq.push_back(b);
      end else
         for (int k = 0; k < n; k++) begin
            b.idx = 3'(k); b.last = k == n - 1; b.err = 1'b0;
            for (int i = 0; i < 3; i++) begin
               b.op[i] = en[i] ? vrf[(int'(vs[i]) + k) % 32] : '0;
               if (en[i]) rq[i].push_back(5'((int'(vs[i]) + k) % 32));
            end
            bq.push_back(b);
         end
      bus.req_vs = vs; bus.req_src_en = en; bus.req_lmul_log2 = lmul; bus.req_tag = tag;
      bus.req_valid = 1'b1;
   endtask
   task automatic run(input logic [2:0][4:0] vs, input logic [2:0] en, input logic [1:0] lmul,
                      input logic [TAG_W-1:0] tag, input int mode);
      bit mis;
      for (int n = 0; n < 50 && !bus.req_ready; n++) tick(0);
      chk("req_ready_wait", bus.req_ready, 1);
      push_exp(vs, en, lmul, tag, mis);
      tick(mode);
      bus.req_valid = 1'b0;
      chk("acc_req_ready", bus.req_ready, 0);
      chk("acc_rd_en", bus.rd_en, mis ? 3'b000 : en);
      chk("acc_valid", bus.out_valid, mis);
      if (!mis) begin
         tick(mode);
         chk("first_valid", bus.out_valid, 1);
      end
      for (int n = 0; n < 200 && bq.size() != 0; n++) tick(mode);
      chk("beats_left", bq.size(), 0);
      tick(0);
      chk("done_req_ready", bus.req_ready, 1);
      for (int i = 0; i < 3; i++) chk("reads_left", rq[i].size(), 0);
   endtask
   initial begin
      bit m;
      for (int r = 0; r < 32; r++)
         for (int j = 0; j < XLEN / 32; j++) vrf[r][j*32 +: 32] = $urandom;
      bus.req_valid = 1'b0; bus.req_vs = '0; bus.req_src_en = '0;
      bus.req_lmul_log2 = '0; bus.req_tag = '0; bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_idx", bus.out_idx, 0);
      chk("rst_out_last", bus.out_last, 0);
      chk("rst_out_tag", bus.out_tag, 0);
      chk("rst_out_err", bus.out_err, 0);
      chk("rst_rd_en", bus.rd_en, 0);
      chk("rst_rd_addr", bus.rd_addr, 0);
      chk("rst_req_ready", bus.req_ready, 1);
      run({5'd7, 5'd5, 5'd3}, 3'b111, 2'd0, 4'h5, 0);
      run({5'd24, 5'd16, 5'd8}, 3'b011, 2'd2, 4'ha, 0);
      stall_left = 3;
      run({5'd16, 5'd8, 5'd0}, 3'b111, 2'd3, 4'h7, 2);
      chk("stall_used", stall_left, 0);
`ifdef VEC_OPF_ALIGN_CHK_EN
      run({5'd0, 5'd0, 5'd6}, 3'b001, 2'd2, 4'hc, 0);
`else
      run({5'd0, 5'd0, 5'd30}, 3'b001, 2'd2, 4'hc, 0);
`endif
      push_exp({5'd12, 5'd4, 5'd0}, 3'b111, 2'd2, 4'h3, m);
      tick(0);
      bus.req_valid = 1'b0;
      for (int n = 0; n < 20 && !(bus.out_valid && bus.out_idx == 3'd1); n++) tick(0);
      chk("mid_idx", bus.out_idx, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", bus.out_valid, 0);
      chk("mid_rst_rd_en", bus.rd_en, 0);
      bq.delete();
      for (int i = 0; i < 3; i++) rq[i].delete();
      tick(0);
      rst_n = 1'b1;
      tick(0);
      chk("mid_rel_req_ready", bus.req_ready, 1);
      chk("mid_rel_valid", bus.out_valid, 0);
      run({5'd20, 5'd2, 5'd9}, 3'b101, 2'd0, 4'h6, 0);
      run({5'd11, 5'd22, 5'd1}, 3'b000, 2'd1, 4'h9, 0);
      for (int t = 0; t < 12; t++)
         run({5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))},
             3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 1);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
